// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared definitions for the shift sequencer. Holds the mode
//               codes, direction codes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    // Fill-mode codes
    localparam logic [1:0] MODE_LOG = 2'b00;  // serial-in fill
    localparam logic [1:0] MODE_ARI = 2'b01;  // arithmetic (sign-extend right, zero left)
    localparam logic [1:0] MODE_ROT = 2'b10;  // rotate
    localparam logic [1:0] MODE_ONE = 2'b11;  // ones fill

    // Shift direction codes
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Sequencer state encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_seq_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_step
// Description : Combinational single-bit shift datapath.
//   p        in  WIDTH  current register value
//   dir      in  1      0 = left, 1 = right
//   mode     in  2      fill mode (see shift_seq_pkg)
//   s_in     in  1      serial fill bit (logical mode only)
//   next_p   out WIDTH  register value after one shift
//   out_bit  out 1      bit leaving the register
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] p,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             s_in,
    output logic [WIDTH-1:0] next_p,
    output logic             out_bit
);

    logic w_fill;

    always_comb begin
        w_fill  = 1'b0;
        next_p  = p;
        out_bit = 1'b0;
        case (dir)
            DIR_L: begin
                case (mode)
                    MODE_LOG: w_fill = s_in;
                    MODE_ARI: w_fill = 1'b0;
                    MODE_ROT: w_fill = p[WIDTH-1];
                    MODE_ONE: w_fill = 1'b1;
                    default:  w_fill = 1'b0;
                endcase
                next_p  = {p[WIDTH-2:0], w_fill};
                out_bit = p[WIDTH-1];
            end
            DIR_R: begin
                case (mode)
                    MODE_LOG: w_fill = s_in;
                    MODE_ARI: w_fill = p[WIDTH-1];
                    MODE_ROT: w_fill = p[0];
                    MODE_ONE: w_fill = 1'b1;
                    default:  w_fill = 1'b0;
                endcase
                next_p  = {w_fill, p[WIDTH-1:1]};
                out_bit = p[0];
            end
            default: begin
                next_p  = p;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq
// Description : Multi-mode shift sequencer. Parallel load in IDLE, then a
//               commanded number of single-bit shifts, one per clock, with a
//               busy level and a one-cycle done pulse.
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous active-high reset
//   ld     in  1      parallel load (IDLE only, wins over start)
//   p_in   in  WIDTH  parallel load data
//   start  in  1      begin shift sequence (IDLE only)
//   amt    in  CNT_W  number of shifts, sampled with start
//   dir    in  1      0 = left, 1 = right, sampled with start
//   mode   in  2      fill mode, sampled with start
//   s_in   in  1      serial fill bit, sampled live each shift
//   p_out  out WIDTH  register contents
//   s_out  out 1      bit shifted out by the most recent shift
//   busy   out 1      high while shifting
//   done   out 1      one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             s_out_q, s_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] w_next_p;
    logic             w_out_bit;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    shift_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p       (p_q),
        .dir     (dir_q),
        .mode    (mode_q),
        .s_in    (s_in),
        .next_p  (w_next_p),
        .out_bit (w_out_bit)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        s_out_d = s_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    p_d = p_in;
                end else if (start) begin
                    if (amt == C_ZERO) begin
                        // Zero-length request completes immediately.
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = amt;
                        dir_d   = dir;
                        mode_d  = mode;
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                p_d     = w_next_p;
                s_out_d = w_out_bit;
                cnt_d   = cnt_q - C_ONE;
                // Last shift: done rises together with the final data.
                if (cnt_q == C_ONE) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_L;
            mode_q  <= MODE_LOG;
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            s_out_q <= s_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign p_out = p_q;
    assign s_out = s_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq
// Description : Directed self-checking bench for shift_seq (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             ld;
    logic [WIDTH-1:0] p_in;
    logic             start;
    logic [CNT_W-1:0] amt;
    logic             dir;
    logic [1:0]       mode;
    logic             s_in;
    logic [WIDTH-1:0] p_out;
    logic             s_out;
    logic             busy;
    logic             done;

    int n_total;
    int n_pass;

    shift_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .p_in  (p_in),
        .start (start),
        .amt   (amt),
        .dir   (dir),
        .mode  (mode),
        .s_in  (s_in),
        .p_out (p_out),
        .s_out (s_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time
    // unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [15:0] seq_ari [4];
        int          busy_cnt;
        seq_ari[0] = 16'hC000;
        seq_ari[1] = 16'hE000;
        seq_ari[2] = 16'hF000;
        seq_ari[3] = 16'hF800;
        n_total = 0;
        n_pass  = 0;

        reset = 1'b1; ld = 1'b0; p_in = '0; start = 1'b0;
        amt = '0; dir = 1'b0; mode = 2'b00; s_in = 1'b0;
        tick(); tick();
        check("rst_p_out", 32'(p_out), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_s_out", 32'(s_out), 32'h0);

        // Parallel load
        reset = 1'b0; ld = 1'b1; p_in = 16'hA5C3;
        tick();
        ld = 1'b0;
        check("ld_p_out", 32'(p_out), 32'hA5C3);
        check("ld_busy",  32'(busy),  32'h0);
        check("ld_done",  32'(done),  32'h0);
        check("ld_s_out", 32'(s_out), 32'h0);

        // Arithmetic right by 4
        ld = 1'b1; p_in = 16'h8001;
        tick();
        ld = 1'b0; start = 1'b1; amt = 5'd4; dir = 1'b1; mode = 2'b01;
        tick();
        start = 1'b0;
        check("ari_busy0", 32'(busy),  32'h1);
        check("ari_p0",    32'(p_out), 32'h8001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ari_p",    32'(p_out), 32'(seq_ari[i]));
            check("ari_busy", 32'(busy),  (i < 3) ? 32'h1 : 32'h0);
            check("ari_done", 32'(done),  (i == 3) ? 32'h1 : 32'h0);
        end
        check("ari_s_out", 32'(s_out), 32'h0);
        tick();
        check("ari_done_end", 32'(done), 32'h0);

        // Rotate left by 1
        ld = 1'b1; p_in = 16'h8001;
        tick();
        ld = 1'b0; start = 1'b1; amt = 5'd1; dir = 1'b0; mode = 2'b10;
        tick();
        start = 1'b0;
        check("rotl_busy", 32'(busy), 32'h1);
        tick();
        check("rotl_p",     32'(p_out), 32'h0003);
        check("rotl_s_out", 32'(s_out), 32'h1);
        check("rotl_busy2", 32'(busy),  32'h0);
        check("rotl_done",  32'(done),  32'h1);
        tick();
        check("rotl_done2", 32'(done), 32'h0);

        // Logical left fill with s_in=1, then rotate right by WIDTH
        ld = 1'b1; p_in = 16'h0000;
        tick();
        ld = 1'b0;
        check("ld_keeps_s_out", 32'(s_out), 32'h1);
        s_in = 1'b1; start = 1'b1; amt = 5'd3; dir = 1'b0; mode = 2'b00;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("logl_p",    32'(p_out), 32'h0007);
        check("logl_done", 32'(done),  32'h1);
        start = 1'b1; amt = 5'd16; dir = 1'b1; mode = 2'b10;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        check("rot16_busy_cycles", 32'(busy_cnt), 32'd16);
        check("rot16_p",           32'(p_out),    32'h0007);
        check("rot16_done",        32'(done),     32'h1);
        check("rot16_busy_end",    32'(busy),     32'h0);

        // amt = 0
        start = 1'b1; amt = 5'd0;
        tick();
        start = 1'b0;
        check("amt0_busy", 32'(busy),  32'h0);
        check("amt0_done", 32'(done),  32'h1);
        check("amt0_p",    32'(p_out), 32'h0007);
        tick();
        check("amt0_done2", 32'(done), 32'h0);

        // ld and start together: load wins
        ld = 1'b1; p_in = 16'h1234; start = 1'b1; amt = 5'd2;
        tick();
        ld = 1'b0; start = 1'b0;
        check("ldst_p",    32'(p_out), 32'h1234);
        check("ldst_busy", 32'(busy),  32'h0);
        check("ldst_done", 32'(done),  32'h0);
        tick();
        check("ldst_busy2", 32'(busy),  32'h0);
        check("ldst_done2", 32'(done),  32'h0);
        check("ldst_p2",    32'(p_out), 32'h1234);

        // amt=8 left logical with s_in=0; ld/start ignored while busy; reset aborts
        s_in = 1'b0; start = 1'b1; amt = 5'd8; dir = 1'b0; mode = 2'b00;
        tick();
        check("abort_busy1", 32'(busy), 32'h1);
        ld = 1'b1; p_in = 16'hFFFF; start = 1'b1; amt = 5'd0;
        tick();
        ld = 1'b0; start = 1'b0;
        check("ign_p",    32'(p_out), 32'h2468);
        check("ign_busy", 32'(busy),  32'h1);
        check("ign_done", 32'(done),  32'h0);
        tick();
        check("ign_p2",   32'(p_out), 32'h48D0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_p",     32'(p_out), 32'h0);
        check("abort_busy",  32'(busy),  32'h0);
        check("abort_done",  32'(done),  32'h0);
        check("abort_s_out", 32'(s_out), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'h0);
            check("abort_no_busy", 32'(busy), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
